// File: rtl/la_capture_ctrl_pkg.sv
// Shared definitions for the logic-analyser capture front-end and its streamer.
// Contents: default sample/address widths, capture FSM state encodings and the
// sync bytes that frame a streamed buffer.
package la_capture_ctrl_pkg;

   localparam int LA_DATA_WIDTH = 8;
   localparam int LA_ADDR_WIDTH = 11;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PRE       = 3'd1;
   localparam logic [2:0] S_WAIT_TRIG = 3'd2;
   localparam logic [2:0] S_POST      = 3'd3;
   localparam logic [2:0] S_STREAM    = 3'd4;

   localparam logic [7:0] LA_SYNC_BYTE_0 = 8'h55;
   localparam logic [7:0] LA_SYNC_BYTE_1 = 8'hAA;

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Sample-BRAM write port plus the capture/streamer handshake.
//   wr_en, wr_addr, wr_data : BRAM write port driven by the capture controller
//   stream_start            : held high while the streamer owns the buffer
//   stream_done             : one-cycle pulse from the streamer when finished
// master = capture controller, slave = BRAM / streamer side.
interface la_capture_ctrl_if #(
   parameter int DW = 8,
   parameter int AW = 11
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          stream_start;
   logic          stream_done;

   modport master (
      output wr_en, wr_addr, wr_data, stream_start,
      input  stream_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, stream_start,
      output stream_done
   );
endinterface

// File: rtl/la_capture_ctrl_trig.sv
// la_trigger_match: combinational mask/value/edge trigger evaluation for one sample.
//   din_i        : current sample
//   prev_i       : previous captured sample, valid only when prev_valid_i
//   mask_i       : 1 = bit participates
//   value_i      : required level, or target value after a transition
//   edge_i       : 1 = bit is edge-qualified
//   hit_o        : every masked bit satisfied (mask==0 always hits)
module la_trigger_match #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] din_i,
   input  logic [DW-1:0] prev_i,
   input  logic          prev_valid_i,
   input  logic [DW-1:0] mask_i,
   input  logic [DW-1:0] value_i,
   input  logic [DW-1:0] edge_i,
   output logic          hit_o
);
   logic [DW-1:0] level_ok;
   logic [DW-1:0] moved;
   logic [DW-1:0] bit_ok;

   assign level_ok = din_i ~^ value_i;
   // A transition needs a real previous sample that differed from the target.
   assign moved    = {DW{prev_valid_i}} & (prev_i ^ value_i);
   assign bit_ok   = ~mask_i | (level_ok & (~edge_i | moved));
   assign hit_o    = &bit_ok;
endmodule

// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: capture front-end of the logic analyser.
// Arms on command, writes sampled words into the sample BRAM as a circular
// buffer, keeps pretrig_len samples of history, waits for the trigger, fills
// the remainder of the buffer and then hands it to the streamer.
//   clk, rst            : system clock, async active-high reset
//   arm_i, abort_i      : start capture from IDLE / drop back to IDLE
//   sample_en_i, din_i  : sample strobe and synchronised probe word
//   trig_*_i            : trigger mask/value/edge, latched on arm
//   pretrig_len_i       : pre-trigger history length, latched on arm
//   trigger_index_o     : buffer address of the trigger sample
//   capture_busy_o      : high in PRE, WAIT_TRIG, POST
//   triggered_o         : trigger seen since the last arm
//   bus                 : BRAM write port and stream handshake
//
// state     | meaning
// IDLE      | waiting for arm
// PRE       | filling pre-trigger history, trigger not evaluated
// WAIT_TRIG | writing freely around the ring, evaluating trigger
// POST      | filling the samples after the trigger
// STREAM    | buffer owned by the streamer until stream_done
module la_capture_ctrl
   import la_capture_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = LA_DATA_WIDTH,
   parameter int ADDR_WIDTH = LA_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm_i,
   input  logic                  abort_i,
   input  logic                  sample_en_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic [DATA_WIDTH-1:0] trig_mask_i,
   input  logic [DATA_WIDTH-1:0] trig_value_i,
   input  logic [DATA_WIDTH-1:0] trig_edge_i,
   input  logic [ADDR_WIDTH-1:0] pretrig_len_i,
   output logic [ADDR_WIDTH-1:0] trigger_index_o,
   output logic                  capture_busy_o,
   output logic                  triggered_o,
   la_capture_ctrl_if.master     bus
);
   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;

   logic [2:0]    state_q,     state_d;
   logic [AW:0]   cnt_q,       cnt_d;
   logic [AW-1:0] ptr_q,       ptr_d;
   logic          wr_en_q,     wr_en_d;
   logic [AW-1:0] wr_addr_q,   wr_addr_d;
   logic [DW-1:0] wr_data_q,   wr_data_d;
   logic [AW-1:0] trig_idx_q,  trig_idx_d;
   logic          triggered_q, triggered_d;
   logic [DW-1:0] prev_q,      prev_d;
   logic          prev_vld_q,  prev_vld_d;
   logic [DW-1:0] mask_q,      mask_d;
   logic [DW-1:0] value_q,     value_d;
   logic [DW-1:0] edge_q,      edge_d;
   logic [AW-1:0] pre_q,       pre_d;

   logic          hit;
   logic          capture;
   logic          in_capture;
   logic [AW:0]   cnt_inc;
   logic [AW:0]   post_len;

   la_trigger_match #(.DW(DW)) u_match (
      .din_i        (din_i),
      .prev_i       (prev_q),
      .prev_valid_i (prev_vld_q),
      .mask_i       (mask_q),
      .value_i      (value_q),
      .edge_i       (edge_q),
      .hit_o        (hit)
   );

   assign cnt_inc    = cnt_q + {{AW{1'b0}}, 1'b1};
   // Samples after the trigger so that pre + trigger + post fills the buffer.
   assign post_len   = {1'b0, {AW{1'b1}}} - {1'b0, pre_q};
   assign in_capture = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      trig_idx_d  = trig_idx_q;
      triggered_d = triggered_q;
      prev_d      = prev_q;
      prev_vld_d  = prev_vld_q;
      mask_d      = mask_q;
      value_d     = value_q;
      edge_d      = edge_q;
      pre_d       = pre_q;
      capture     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (arm_i && !abort_i) begin
               mask_d      = trig_mask_i;
               value_d     = trig_value_i;
               edge_d      = trig_edge_i;
               pre_d       = pretrig_len_i;
               cnt_d       = '0;
               ptr_d       = '0;
               triggered_d = 1'b0;
               prev_vld_d  = 1'b0;
               state_d     = (pretrig_len_i == '0) ? S_WAIT_TRIG : S_PRE;
            end
         end
         S_PRE: begin
            if (sample_en_i) begin
               capture = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == {1'b0, pre_q}) state_d = S_WAIT_TRIG;
            end
         end
         S_WAIT_TRIG: begin
            if (sample_en_i) begin
               capture = 1'b1;
               if (hit) begin
                  trig_idx_d  = ptr_q;
                  triggered_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = (post_len == '0) ? S_STREAM : S_POST;
               end
            end
         end
         S_POST: begin
            if (sample_en_i) begin
               capture = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == post_len) state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (bus.stream_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (capture) begin
         wr_en_d    = 1'b1;
         wr_addr_d  = ptr_q;
         wr_data_d  = din_i;
         ptr_d      = ptr_q + {{(AW-1){1'b0}}, 1'b1};
         prev_d     = din_i;
         prev_vld_d = 1'b1;
      end

      // The sample taken in the abort cycle is still written; only the state unwinds.
      if (abort_i && in_capture) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ptr_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         trig_idx_q  <= '0;
         triggered_q <= 1'b0;
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
         mask_q      <= '0;
         value_q     <= '0;
         edge_q      <= '0;
         pre_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         trig_idx_q  <= trig_idx_d;
         triggered_q <= triggered_d;
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
         mask_q      <= mask_d;
         value_q     <= value_d;
         edge_q      <= edge_d;
         pre_q       <= pre_d;
      end
   end

   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.stream_start = (state_q == S_STREAM);
   assign trigger_index_o  = trig_idx_q;
   assign capture_busy_o   = in_capture;
   assign triggered_o      = triggered_q;
endmodule
